lamp: RTL and testbench
=======================

LAMP -- requirements
Module: lamp

Interface
REQ-001 Parameter c_freq, default 12_000_000, input clock frequency in Hz; SHALL be a multiple of 1000 and at least 1000.
REQ-002 Parameter c_blink_ms, default 250, half-period of o_led1 in milliseconds, range 1..65535.
REQ-003 Parameter c_step_ms, default 4, milliseconds between breathing duty steps, range 1..255.
REQ-004 i_clk  input  1  sole clock; all logic on rising edge.
REQ-005 i_rst  input  1  reset, synchronous, active-high.
REQ-006 o_led1  output  1  blink LED, registered.
REQ-007 o_led2  output  1  breathing (PWM) LED, registered.

Function
REQ-008 Millisecond tick: prescaler counts 0..c_freq/1000-1, wraps to 0; one-cycle tick pulse when prescaler equals c_freq/1000-1.
REQ-009 First tick SHALL occur on the (c_freq/1000)th rising edge after i_rst deasserts; subsequent ticks every c_freq/1000 cycles exactly.
REQ-010 Blink counter counts ticks 0..c_blink_ms-1; on the tick at which it equals c_blink_ms-1 it wraps to 0 and o_led1 toggles on the same edge.
REQ-011 o_led1 therefore SHALL have period 2*c_blink_ms ms, 50% duty, first rise c_blink_ms*c_freq/1000 cycles after reset release.
REQ-012 Step counter counts ticks 0..c_step_ms-1; at wrap it issues one duty step.
REQ-013 Duty: 8-bit unsigned, direction flag up/down; on step, up: duty+1, down: duty-1.
REQ-014 Direction SHALL flip to down on the step that makes duty 255, and to up on the step that makes duty 0; duty never wraps past 0 or 255.
REQ-015 PWM counter: 8-bit free-running, increments every clock, wraps 255->0.
REQ-016 o_led2 SHALL be registered (pwm_cnt < duty), one cycle latency from counter; duty 0 gives constant 0, duty 255 gives 255 high cycles per 256.
REQ-017 Full breathing cycle SHALL be 510 steps (510*c_step_ms ms).
REQ-018 A duty change SHALL take effect immediately in the compare; no PWM-period alignment required.

Reset
REQ-019 While i_rst high at a clock edge: prescaler, blink, step, PWM counters and duty cleared to 0, direction up, o_led1=0, o_led2=0.
REQ-020 Reset asserted mid-operation SHALL override all counting on that edge; timing restarts from REQ-009 after release.

Configuration
REQ-021 Macro LAMP_BREATH_EN defined: o_led2 behaves per REQ-012..REQ-018.
REQ-022 LAMP_BREATH_EN undefined: step/duty/PWM logic omitted; o_led2 SHALL be registered complement of o_led1 (one cycle behind its toggle), 0 during reset.

Structure
REQ-023 Package lamp_pkg SHALL hold duty width (8), PWM width (8), default parameter values and the direction encoding (UP=0, DOWN=1).
REQ-024 Sub-module lamp_tick SHALL implement the millisecond prescaler (parameter c_freq, outputs tick); lamp instantiates it once.

Verification (c_freq=10_000_000, 10 MHz clock, defaults unless stated)
REQ-025 Reset held 5 cycles then released -> o_led1=0, o_led2=0 during reset; first tick at cycle 10_000 after release.
REQ-026 Run 1 s -> o_led1 rises at 250 ms, falls at 500 ms, rises at 750 ms, falls at 1000 ms (±1 cycle).
REQ-027 LAMP_BREATH_EN, c_step_ms=1 -> duty 10 at 10 ms, o_led2 high exactly 10 of every 256 cycles; duty 255 at 255 ms, direction down, duty 254 at 256 ms, duty 0 at 510 ms then rising.
REQ-028 LAMP_BREATH_EN, run 1 s with c_step_ms=4 -> duty 250 at 1000 ms, never exceeding 255.
REQ-029 Reset pulsed 1 cycle at 300 ms -> all outputs 0 next cycle; o_led1 next rises 250 ms after release.
REQ-030 LAMP_BREATH_EN undefined -> o_led2 equals ~o_led1 delayed one cycle across 1 s run.

Source files
------------

// File: rtl/lamp_pkg.sv
// Shared widths, default parameter values and direction encoding for the lamp block.
// Optional breathing LED is enabled with the LAMP_BREATH_EN macro.
package lamp_pkg;

  localparam int DUTY_W = 8;
  localparam int PWM_W  = 8;

  localparam int DEF_FREQ     = 12_000_000;
  localparam int DEF_BLINK_MS = 250;
  localparam int DEF_STEP_MS  = 4;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lamp_tick.sv
// Millisecond prescaler: tick is high for the one cycle in which the
// prescaler sits at its terminal count c_freq/1000-1.
module lamp_tick
  import lamp_pkg::*;
#(
  parameter int c_freq = DEF_FREQ
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic tick
);

  localparam int DIV = c_freq / 1000;
  localparam int W   = cnt_width(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] presc_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      presc_reg <= '0;
    end else if (presc_reg == LAST) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end

  assign tick = (presc_reg == LAST);

endmodule

// File: rtl/lamp.sv
// Status lamp: o_led1 blinks at c_blink_ms half-period; o_led2 breathes via PWM when
// LAMP_BREATH_EN is defined, otherwise it is the complement of o_led1 one cycle late.
module lamp
  import lamp_pkg::*;
#(
  parameter int c_freq     = DEF_FREQ,
  parameter int c_blink_ms = DEF_BLINK_MS,
  parameter int c_step_ms  = DEF_STEP_MS
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_led1,
  output logic o_led2
);

  if (c_freq < 1000 || (c_freq % 1000) != 0) begin : g_bad_freq
    $error("lamp: c_freq must be a multiple of 1000 and at least 1000");
  end
  if (c_blink_ms < 1 || c_blink_ms > 65535) begin : g_bad_blink
    $error("lamp: c_blink_ms out of range 1..65535");
  end
  if (c_step_ms < 1 || c_step_ms > 255) begin : g_bad_step
    $error("lamp: c_step_ms out of range 1..255");
  end
  if (DUTY_W != PWM_W) begin : g_bad_width
    $error("lamp: duty and PWM counter widths must match for the compare");
  end

  localparam logic [15:0] BLINK_LAST = 16'(c_blink_ms - 1);

  logic        tick;
  logic [15:0] blink_reg;
  logic        led1_reg;
  logic        led2_reg;

  lamp_tick #(
    .c_freq(c_freq)
  ) u_tick (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .tick (tick)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      blink_reg <= '0;
      led1_reg  <= 1'b0;
    end else if (tick) begin
      if (blink_reg == BLINK_LAST) begin
        blink_reg <= '0;
        led1_reg  <= ~led1_reg;
      end else begin
        blink_reg <= blink_reg + 1'b1;
      end
    end
  end

`ifdef LAMP_BREATH_EN
  localparam logic [7:0]        STEP_LAST = 8'(c_step_ms - 1);
  localparam logic [DUTY_W-1:0] DUTY_MAX  = '1;

  logic [7:0]        step_reg;
  logic [DUTY_W-1:0] duty_reg, duty_next;
  dir_t              dir_reg, dir_next;
  logic [PWM_W-1:0]  pwm_reg;
  logic              step_stb;

  assign step_stb = tick && (step_reg == STEP_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      step_reg <= '0;
      duty_reg <= '0;
      dir_reg  <= DIR_UP;
      pwm_reg  <= '0;
      led2_reg <= 1'b0;
    end else begin
      if (tick) begin
        step_reg <= step_stb ? '0 : step_reg + 1'b1;
      end
      duty_reg <= duty_next;
      dir_reg  <= dir_next;
      pwm_reg  <= pwm_reg + 1'b1;
      // Compare uses the live duty so a step lands mid PWM period.
      led2_reg <= (pwm_reg < duty_reg);
    end
  end

  // Direction flips on the step that reaches an end, so duty never wraps.
  always_comb begin
    duty_next = duty_reg;
    dir_next  = dir_reg;
    if (step_stb) begin
      case (dir_reg)
        DIR_UP: begin
          duty_next = duty_reg + 1'b1;
          if (duty_next == DUTY_MAX) dir_next = DIR_DOWN;
        end
        default: begin
          duty_next = duty_reg - 1'b1;
          if (duty_next == '0) dir_next = DIR_UP;
        end
      endcase
    end
  end
`else
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      led2_reg <= 1'b0;
    end else begin
      led2_reg <= ~led1_reg;
    end
  end
`endif

  assign o_led1 = led1_reg;
  assign o_led2 = led2_reg;

endmodule

// File: tb/tb_lamp.sv
// Self-checking bench for lamp: a timing model driven by the count of clock edges
// since reset release predicts both LEDs every cycle, plus hand-computed anchor points.
module tb_lamp;

  localparam int C_FREQ = 4000;
  localparam int P      = C_FREQ / 1000;
  localparam int BLINK  = 5;
  localparam int STEP   = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic led1;
  logic led2;

  int   n_checks = 0;
  int   n_fail   = 0;

  int   c        = 0;
  bit   valid    = 1'b0;
  logic exp_led1 = 1'b0;
  logic exp_led2 = 1'b0;

  always #5 clk = ~clk;

  lamp #(
    .c_freq    (C_FREQ),
    .c_blink_ms(BLINK),
    .c_step_ms (STEP)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .o_led1(led1),
    .o_led2(led2)
  );

  // Blink state after n edges out of reset: toggles every BLINK whole milliseconds.
  function automatic logic m_led1(input int n);
    return (((n / P) / BLINK) % 2) == 1;
  endfunction

  // Breathing duty is a 510-step triangle: 0 up to 255 and back down to 0.
  function automatic int m_duty(input int n);
    int s;
    s = ((n / P) / STEP) % 510;
    return (s <= 255) ? s : 510 - s;
  endfunction

  // o_led2 after the edge following state n.
  function automatic logic m_led2(input int n);
`ifdef LAMP_BREATH_EN
    return (n % 256) < m_duty(n);
`else
    return ~m_led1(n);
`endif
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (edge %0d after release, t=%0t)", name, act, exp, c, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b1;
      c        <= 0;
      exp_led1 <= 1'b0;
      exp_led2 <= 1'b0;
    end else if (valid) begin
      c        <= c + 1;
      exp_led1 <= m_led1(c + 1);
      exp_led2 <= m_led2(c);
    end
  end

  always @(negedge clk) begin
    if (valid) begin
      check("led1_model", led1, exp_led1);
      check("led2_model", led2, exp_led2);
      if (!rst) begin
        if (c == 19) check("led1_before_first_rise", led1, 1'b0);
        if (c == 20) check("led1_first_rise", led1, 1'b1);
        if (c == 39) check("led1_before_first_fall", led1, 1'b1);
        if (c == 40) check("led1_first_fall", led1, 1'b0);
        if (c == 60) check("led1_second_rise", led1, 1'b1);
`ifdef LAMP_BREATH_EN
        if (c == 1)   check("led2_start_dark", led2, 1'b0);
        if (c == 41)  check("led2_duty10_pwm40", led2, 1'b0);
        if (c == 300) check("led2_duty74_pwm43", led2, 1'b1);
`else
        if (c == 1)  check("led2_first_complement", led2, 1'b1);
        if (c == 20) check("led2_lags_rise", led2, 1'b1);
        if (c == 21) check("led2_after_rise", led2, 1'b0);
        if (c == 41) check("led2_after_fall", led2, 1'b1);
`endif
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("reset_led1", led1, 1'b0);
      check("reset_led2", led2, 1'b0);
    end
    rst = 1'b0;

    // Run into a lit half-period, then pulse reset for one cycle.
    repeat (1300) @(negedge clk);
    check("led1_lit_before_pulse", led1, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("pulse_led1", led1, 1'b0);
    check("pulse_led2", led2, 1'b0);
    rst = 1'b0;

    // Long enough to cover a full breathing cycle after the restart.
    repeat (2200) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
